// File: rtl/vec_read_arbiter_pkg.sv
// Shared types and constants for the vector-tile read arbiter.
// Requester slot indices, buffer-id width and FSM state encoding.
package vec_read_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } vra_state_t;

  localparam int NUM_VEC_READERS = 4;

  localparam int REQ_STORE = 0;
  localparam int REQ_LOAD  = 1;
  localparam int REQ_ACT   = 2;
  localparam int REQ_GEMV  = 3;

  localparam int BUF_ID_W = 5;

endpackage

// File: rtl/vec_read_arbiter_picker.sv
// Round-robin priority picker: first set bit of cand at or after ptr.
// Ports: cand (candidates), ptr (start index), found, idx (winner).
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (cand[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/vec_read_arbiter.sv
// Round-robin arbiter sharing one vector-tile read port among requesters.
// Ports: req_* (requester side), buf_read_* (buffer side), busy, err_*.
module vec_read_arbiter
  import vec_read_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_WIDTH = 256,
  parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
  parameter int NUM_REQ    = NUM_VEC_READERS,
  parameter int TIMEOUT    = 255
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_REQ-1:0]                          req_enable,
  input  logic [NUM_REQ-1:0][BUF_ID_W-1:0]            req_buffer_id,
  output logic [NUM_REQ-1:0]                          req_valid,
  output logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0] req_tile,
  output logic                                        buf_read_enable,
  output logic [BUF_ID_W-1:0]                         buf_read_buffer_id,
  input  logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0] buf_read_tile,
  input  logic                                        buf_read_valid,
  output logic                                        busy,
  input  logic                                        err_clear,
  output logic                                        err_overflow,
  output logic                                        err_timeout,
  output logic                                        err_spurious
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  vra_state_t state, state_n;

  logic [NUM_REQ-1:0]               pending;
  logic [NUM_REQ-1:0][BUF_ID_W-1:0] id_q;
  logic [IW-1:0]                    rr_ptr;
  logic [IW-1:0]                    grant;
  logic [CW-1:0]                    cnt;

  logic [NUM_REQ-1:0]  cand;
  logic                found;
  logic [IW-1:0]       pick;
  logic                issue;
  logic                rsp;
  logic                tmo;
  logic                spur;
  logic                ovf;
  logic [NUM_REQ-1:0]  clr;
  logic [NUM_REQ-1:0]  acc;
  logic [BUF_ID_W-1:0] pick_id;
  logic [IW-1:0]       nxt_ptr;

  assign cand = pending | req_enable;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .cand  (cand),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      issue:     state_n = WAIT;
      rsp | tmo: state_n = IDLE;
      default:   state_n = state;
    endcase
  end

  // A pulse landing on the slot being retired this cycle is a fresh
  // request, not an overflow: set wins over clear.
  always_comb begin
    issue = (state == IDLE) & found;
    rsp   = (state == WAIT) & buf_read_valid;
    tmo   = (state == WAIT) & ~buf_read_valid
          & (cnt == CW'(TIMEOUT - 1));
    spur  = (state == IDLE) & buf_read_valid;
    clr   = '0;
    if (rsp | tmo) clr[grant] = 1'b1;
    acc     = req_enable & ~(pending & ~clr);
    ovf     = |(req_enable & pending & ~clr);
    pick_id = acc[pick] ? req_buffer_id[pick] : id_q[pick];
    nxt_ptr = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending            <= '0;
      id_q               <= '0;
      rr_ptr             <= '0;
      grant              <= '0;
      cnt                <= '0;
      req_valid          <= '0;
      req_tile           <= '0;
      buf_read_enable    <= 1'b0;
      buf_read_buffer_id <= '0;
      err_overflow       <= 1'b0;
      err_timeout        <= 1'b0;
      err_spurious       <= 1'b0;
    end else begin
      buf_read_enable <= 1'b0;
      req_valid       <= '0;
      pending         <= (pending & ~clr) | acc;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) id_q[i] <= req_buffer_id[i];
      end
      if (issue) begin
        grant              <= pick;
        buf_read_enable    <= 1'b1;
        buf_read_buffer_id <= pick_id;
        cnt                <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (rsp) begin
        req_tile         <= buf_read_tile;
        req_valid[grant] <= 1'b1;
      end
      if (rsp | tmo) rr_ptr <= nxt_ptr;
      err_overflow <= ovf  | (err_overflow & ~err_clear);
      err_timeout  <= tmo  | (err_timeout  & ~err_clear);
      err_spurious <= spur | (err_spurious & ~err_clear);
    end
  end

  assign busy = (state == WAIT) | (|pending);

endmodule

// File: tb/tb_vec_read_arbiter.sv
// Directed bench for vec_read_arbiter.
// Covers single read, contention, fairness, errors and mid-read reset.
module tb_vec_read_arbiter;
  import vec_read_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int TE = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NR-1:0]             req_enable;
  logic [NR-1:0][4:0]        req_buffer_id;
  logic [NR-1:0]             req_valid;
  logic [TE-1:0][7:0]        req_tile;
  logic                      buf_read_enable;
  logic [4:0]                buf_read_buffer_id;
  logic [TE-1:0][7:0]        buf_read_tile;
  logic                      buf_read_valid;
  logic                      busy;
  logic                      err_clear;
  logic                      err_overflow;
  logic                      err_timeout;
  logic                      err_spurious;

  int total = 0;
  int bad   = 0;

  vec_read_arbiter #(
    .DATA_WIDTH (8),
    .TILE_WIDTH (256),
    .NUM_REQ    (NR),
    .TIMEOUT    (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_enable         (req_enable),
    .req_buffer_id      (req_buffer_id),
    .req_valid          (req_valid),
    .req_tile           (req_tile),
    .buf_read_enable    (buf_read_enable),
    .buf_read_buffer_id (buf_read_buffer_id),
    .buf_read_tile      (buf_read_tile),
    .buf_read_valid     (buf_read_valid),
    .busy               (busy),
    .err_clear          (err_clear),
    .err_overflow       (err_overflow),
    .err_timeout        (err_timeout),
    .err_spurious       (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_tile(input logic [7:0] e0);
    logic [255:0] t;
    t          = '0;
    t[7:0]     = e0;
    t[135:128] = 8'h5A;
    t[255:248] = ~e0;
    return t;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Called in the cycle buf_read_enable should be high; returns the
  // tile two cycles later and optionally re-pulses in the req_valid cycle.
  task automatic serve(input int idx, input logic [4:0] id,
                       input logic [7:0] e0, input logic [3:0] again);
    logic [255:0] t;
    logic [3:0]   m;
    t = mk_tile(e0);
    m = 4'b0001 << idx;
    chk("rd_en", 256'(buf_read_enable), 256'(1'b1));
    chk("rd_id", 256'(buf_read_buffer_id), 256'(id));
    chk("busy_rd", 256'(busy), 256'(1'b1));
    step();
    chk("rd_pulse", 256'(buf_read_enable), 256'(1'b0));
    step();
    buf_read_valid = 1'b1;
    buf_read_tile  = t;
    step();
    buf_read_valid = 1'b0;
    buf_read_tile  = '0;
    chk("rvalid", 256'(req_valid), 256'(m));
    chk("rtile", req_tile, t);
    req_enable = again;
    step();
    req_enable = '0;
    chk("rtile_hold", req_tile, t);
  endtask

  initial begin
    rst            = 1'b1;
    req_enable     = '0;
    req_buffer_id  = '0;
    buf_read_tile  = '0;
    buf_read_valid = 1'b0;
    err_clear      = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("rst_rd_en", 256'(buf_read_enable), 256'(1'b0));
    chk("rst_rd_id", 256'(buf_read_buffer_id), 256'(5'd0));
    chk("rst_rv", 256'(req_valid), 256'(4'd0));
    chk("rst_tile", req_tile, 256'd0);
    chk("rst_busy", 256'(busy), 256'(1'b0));
    chk("rst_errs", 256'({err_overflow, err_timeout, err_spurious}),
        256'(3'b000));

    // single request from the activation unit
    req_buffer_id[REQ_ACT] = 5'd7;
    req_enable = 4'b0100;
    step();
    req_enable = '0;
    serve(2, 5'd7, 8'hFB, 4'b0000);
    chk("t1_tile0", 256'(req_tile[0]), 256'(8'hFB));
    chk("t1_idle", 256'(busy), 256'(1'b0));

    // contention, round-robin from 0
    do_reset();
    req_buffer_id = {5'd4, 5'd3, 5'd2, 5'd1};
    req_enable = 4'b1111;
    step();
    req_enable = '0;
    serve(0, 5'd1, 8'h11, 4'b0000);
    serve(1, 5'd2, 8'h12, 4'b0000);
    serve(2, 5'd3, 8'h13, 4'b0000);
    serve(3, 5'd4, 8'h14, 4'b0000);
    chk("t2_busy", 256'(busy), 256'(1'b0));
    chk("t2_ptr", 256'(dut.rr_ptr), 256'(2'd0));
    chk("t2_no_rd", 256'(buf_read_enable), 256'(1'b0));

    // fairness: 0 keeps re-pulsing against 3
    req_enable = 4'b1001;
    step();
    req_enable = '0;
    serve(0, 5'd1, 8'h21, 4'b0001);
    serve(3, 5'd4, 8'h22, 4'b1000);
    serve(0, 5'd1, 8'h23, 4'b0001);
    serve(3, 5'd4, 8'h24, 4'b0000);
    serve(0, 5'd1, 8'h25, 4'b0000);
    chk("t3_busy", 256'(busy), 256'(1'b0));

    // reset while a read is outstanding
    req_enable = 4'b1010;
    step();
    req_enable = '0;
    chk("t4_rd_en", 256'(buf_read_enable), 256'(1'b1));
    chk("t4_rd_id", 256'(buf_read_buffer_id), 256'(5'd2));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_rd_en0", 256'(buf_read_enable), 256'(1'b0));
    chk("t4_rd_id0", 256'(buf_read_buffer_id), 256'(5'd0));
    chk("t4_tile0", req_tile, 256'd0);
    chk("t4_busy0", 256'(busy), 256'(1'b0));
    chk("t4_pend0", 256'(dut.pending), 256'(4'd0));
    buf_read_valid = 1'b1;
    step();
    buf_read_valid = 1'b0;
    chk("t4_spur", 256'(err_spurious), 256'(1'b1));
    chk("t4_rv0", 256'(req_valid), 256'(4'd0));
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("t4_spur_clr", 256'(err_spurious), 256'(1'b0));

    // overflow: second pulse while pending keeps the first id
    req_buffer_id[REQ_LOAD] = 5'd9;
    req_enable = 4'b0010;
    step();
    req_enable = '0;
    chk("t5_rd_en", 256'(buf_read_enable), 256'(1'b1));
    chk("t5_rd_id", 256'(buf_read_buffer_id), 256'(5'd9));
    req_buffer_id[REQ_LOAD] = 5'd12;
    req_enable = 4'b0010;
    step();
    req_enable = '0;
    chk("t5_ovf", 256'(err_overflow), 256'(1'b1));
    buf_read_valid = 1'b1;
    buf_read_tile  = mk_tile(8'h31);
    step();
    buf_read_valid = 1'b0;
    chk("t5_rv", 256'(req_valid), 256'(4'b0010));
    chk("t5_ovf_hold", 256'(err_overflow), 256'(1'b1));
    step();
    chk("t5_busy", 256'(busy), 256'(1'b0));
    chk("t5_no_rd", 256'(buf_read_enable), 256'(1'b0));
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("t5_ovf_clr", 256'(err_overflow), 256'(1'b0));

    // pulse coinciding with its own response: set wins over clear
    req_buffer_id[REQ_LOAD] = 5'd9;
    req_enable = 4'b0010;
    step();
    req_enable = '0;
    chk("t6_rd_id", 256'(buf_read_buffer_id), 256'(5'd9));
    step();
    buf_read_valid = 1'b1;
    req_buffer_id[REQ_LOAD] = 5'd12;
    req_enable = 4'b0010;
    step();
    buf_read_valid = 1'b0;
    req_enable = '0;
    chk("t6_rv", 256'(req_valid), 256'(4'b0010));
    chk("t6_no_ovf", 256'(err_overflow), 256'(1'b0));
    step();
    chk("t6_rd_en", 256'(buf_read_enable), 256'(1'b1));
    chk("t6_rd_id2", 256'(buf_read_buffer_id), 256'(5'd12));
    buf_read_valid = 1'b1;
    step();
    buf_read_valid = 1'b0;
    chk("t6_rv2", 256'(req_valid), 256'(4'b0010));
    step();
    chk("t6_busy", 256'(busy), 256'(1'b0));

    // timeout after four WAIT cycles, then the next requester
    do_reset();
    req_buffer_id[REQ_STORE] = 5'd3;
    req_buffer_id[REQ_ACT]   = 5'd7;
    req_enable = 4'b0101;
    step();
    req_enable = '0;
    chk("t7_rd_id", 256'(buf_read_buffer_id), 256'(5'd3));
    step();
    step();
    step();
    chk("t7_no_tmo", 256'(err_timeout), 256'(1'b0));
    step();
    chk("t7_tmo", 256'(err_timeout), 256'(1'b1));
    chk("t7_rv0", 256'(req_valid), 256'(4'd0));
    chk("t7_busy", 256'(busy), 256'(1'b1));
    step();
    chk("t7_rd_en2", 256'(buf_read_enable), 256'(1'b1));
    chk("t7_rd_id2", 256'(buf_read_buffer_id), 256'(5'd7));
    repeat (4) step();
    chk("t7_idle", 256'(busy), 256'(1'b0));
    chk("t7_rv0b", 256'(req_valid), 256'(4'd0));
    buf_read_valid = 1'b1;
    step();
    buf_read_valid = 1'b0;
    chk("t7_spur", 256'(err_spurious), 256'(1'b1));
    chk("t7_rv0c", 256'(req_valid), 256'(4'd0));
    buf_read_valid = 1'b1;
    err_clear = 1'b1;
    step();
    buf_read_valid = 1'b0;
    chk("t7_evt_wins", 256'(err_spurious), 256'(1'b1));
    chk("t7_tmo_clr", 256'(err_timeout), 256'(1'b0));
    step();
    err_clear = 1'b0;
    chk("t7_spur_clr", 256'(err_spurious), 256'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
